// File: rtl/cgra_mp_obi_bridge.sv
// cgra_mp_obi_bridge
//   Generic bridge between the CGRA's N_MP TCDM-style master ports and the
//   system OBI masters. Each port is a combinational pass-through, except that
//   issue is gated by a per-port outstanding counter (capped at
//   MAX_OUTSTANDING) and by a quiesce FSM. The FSM owns the logic clock-gate
//   enable and only turns the clock off after every port has drained.
//   CGRA event pulses are collected into sticky, maskable interrupt pending
//   bits.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   enable_req_i         request the CGRA logic clock on
//   clk_en_o             enable to the logic clock-gating cell
//   quiesced_o           high while the FSM is in OFF
//   tcdm_*_i / tcdm_*_o  CGRA-side master ports, port p at [p*W +: W]
//   obi_*_o / obi_*_i    system-side OBI masters, same packing
//   evt_i                CGRA event pulses
//   evt_mask_i           interrupt enable per event
//   evt_clr_i            clear the pending bit per event
//   evt_pending_o        sticky pending bits
//   int_o                interrupt, registered
//   err_o                sticky per-port error: response with nothing outstanding
module cgra_mp_obi_bridge #(
    parameter int unsigned N_MP            = 4,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned N_EVT           = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_req_i,
    output logic                     clk_en_o,
    output logic                     quiesced_o,
    input  logic [N_MP-1:0]          tcdm_req_i,
    input  logic [N_MP*ADDR_W-1:0]   tcdm_add_i,
    input  logic [N_MP-1:0]          tcdm_wen_i,
    input  logic [N_MP*4-1:0]        tcdm_be_i,
    input  logic [N_MP*DATA_W-1:0]   tcdm_wdata_i,
    output logic [N_MP-1:0]          tcdm_gnt_o,
    output logic [N_MP*DATA_W-1:0]   tcdm_rdata_o,
    output logic [N_MP-1:0]          tcdm_rvalid_o,
    output logic [N_MP-1:0]          obi_req_o,
    output logic [N_MP*ADDR_W-1:0]   obi_addr_o,
    output logic [N_MP-1:0]          obi_we_o,
    output logic [N_MP*4-1:0]        obi_be_o,
    output logic [N_MP*DATA_W-1:0]   obi_wdata_o,
    input  logic [N_MP-1:0]          obi_gnt_i,
    input  logic [N_MP*DATA_W-1:0]   obi_rdata_i,
    input  logic [N_MP-1:0]          obi_rvalid_i,
    input  logic [N_EVT-1:0]         evt_i,
    input  logic [N_EVT-1:0]         evt_mask_i,
    input  logic [N_EVT-1:0]         evt_clr_i,
    output logic [N_EVT-1:0]         evt_pending_o,
    output logic                     int_o,
    output logic [N_MP-1:0]          err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt [N_MP];
    logic [N_MP-1:0] allow;
    logic [N_MP-1:0] grant;
    logic [N_MP-1:0] cnt_zero;
    logic [N_EVT-1:0] pending_next;

    // Data path: straight pass-through, only the write-enable polarity flips.
    assign obi_addr_o    = tcdm_add_i;
    assign obi_be_o      = tcdm_be_i;
    assign obi_wdata_o   = tcdm_wdata_i;
    assign obi_we_o      = ~tcdm_wen_i;
    assign tcdm_rdata_o  = obi_rdata_i;
    assign tcdm_rvalid_o = obi_rvalid_i;

    // Issue only in RUN and below the outstanding cap. OFF is the reset
    // state, so no request or grant leaks out while reset is held.
    always_comb begin
        allow    = '0;
        cnt_zero = '0;
        for (int unsigned p = 0; p < N_MP; p++) begin
            allow[p]    = (state == ST_RUN) && (cnt[p] < CW'(MAX_OUTSTANDING));
            cnt_zero[p] = (cnt[p] == '0);
        end
    end

    assign obi_req_o  = tcdm_req_i & allow;
    assign grant      = obi_gnt_i & obi_req_o;
    assign tcdm_gnt_o = grant;

    // Outstanding counters. A response with nothing outstanding (and no
    // grant in the same cycle to pair with) is a protocol error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < N_MP; p++) begin
                cnt[p] <= '0;
            end
            err_o <= '0;
        end else begin
            for (int unsigned p = 0; p < N_MP; p++) begin
                case ({grant[p], obi_rvalid_i[p]})
                    2'b10: cnt[p] <= cnt[p] + CW'(1);
                    2'b01: begin
                        if (cnt_zero[p]) begin
                            err_o[p] <= 1'b1;
                        end else begin
                            cnt[p] <= cnt[p] - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Quiesce FSM; clk_en_o / quiesced_o are registered alongside the state
    // so they always reflect the state being entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_OFF;
            clk_en_o   <= 1'b0;
            quiesced_o <= 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    if (enable_req_i) begin
                        state      <= ST_RUN;
                        clk_en_o   <= 1'b1;
                        quiesced_o <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!enable_req_i) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Re-enable wins over finishing the drain.
                    if (enable_req_i) begin
                        state <= ST_RUN;
                    end else if (&cnt_zero) begin
                        state      <= ST_OFF;
                        clk_en_o   <= 1'b0;
                        quiesced_o <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_OFF;
                    clk_en_o   <= 1'b0;
                    quiesced_o <= 1'b1;
                end
            endcase
        end
    end

    // Events: set wins over clear; int_o looks at the post-update pending
    // bits so it rises one cycle after the event.
    assign pending_next = (evt_pending_o & ~evt_clr_i) | evt_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_pending_o <= '0;
            int_o         <= 1'b0;
        end else begin
            evt_pending_o <= pending_next;
            int_o         <= |(pending_next & evt_mask_i);
        end
    end

endmodule

// File: tb/tb_cgra_mp_obi_bridge.sv
// tb_cgra_mp_obi_bridge
//   Directed bench for cgra_mp_obi_bridge. Instance dut (N_MP=4, MAX=2) is
//   compared every cycle against a transaction-level model; instance dut8
//   (N_MP=8, MAX=1) gets directed checks only.
module tb_cgra_mp_obi_bridge;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;
    localparam int NE = 4;
    localparam int NP8 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    // ---------------- dut (4 ports) ----------------
    logic              en = 1'b0;
    logic              clk_en, quiesced, int_o;
    logic [NP-1:0]     tcdm_req = '0, tcdm_wen = '1, tcdm_gnt, tcdm_rvalid;
    logic [NP*AW-1:0]  tcdm_add = '0, obi_addr;
    logic [NP*4-1:0]   tcdm_be = '0, obi_be;
    logic [NP*DW-1:0]  tcdm_wdata = '0, tcdm_rdata, obi_wdata, obi_rdata = '0;
    logic [NP-1:0]     obi_req, obi_we, obi_gnt = '0, obi_rvalid = '0, err;
    logic [NE-1:0]     evt = '0, evt_mask = '0, evt_clr = '0, pending;

    cgra_mp_obi_bridge #(.N_MP(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .N_EVT(NE)) dut (
        .clk_i(clk), .rst_i(rst), .enable_req_i(en), .clk_en_o(clk_en), .quiesced_o(quiesced),
        .tcdm_req_i(tcdm_req), .tcdm_add_i(tcdm_add), .tcdm_wen_i(tcdm_wen), .tcdm_be_i(tcdm_be),
        .tcdm_wdata_i(tcdm_wdata), .tcdm_gnt_o(tcdm_gnt), .tcdm_rdata_o(tcdm_rdata),
        .tcdm_rvalid_o(tcdm_rvalid), .obi_req_o(obi_req), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
        .obi_be_o(obi_be), .obi_wdata_o(obi_wdata), .obi_gnt_i(obi_gnt), .obi_rdata_i(obi_rdata),
        .obi_rvalid_i(obi_rvalid), .evt_i(evt), .evt_mask_i(evt_mask), .evt_clr_i(evt_clr),
        .evt_pending_o(pending), .int_o(int_o), .err_o(err)
    );

    // ---------------- dut8 (8 ports, one outstanding) ----------------
    logic               en8 = 1'b0;
    logic               clk_en8, quiesced8, int8;
    logic [NP8-1:0]     req8 = '0, wen8 = '1, gnt8_o, rvalid8_o, oreq8, owe8, gnt8 = '0, rvalid8 = '0, err8;
    logic [NP8*AW-1:0]  add8 = '0, oaddr8;
    logic [NP8*4-1:0]   be8 = '0, obe8;
    logic [NP8*DW-1:0]  wdata8 = '0, rdata8_o, owdata8, rdata8 = '0;
    logic [NE-1:0]      evt8 = '0, mask8 = '0, clr8 = '0, pend8;

    cgra_mp_obi_bridge #(.N_MP(NP8), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(1), .N_EVT(NE)) dut8 (
        .clk_i(clk), .rst_i(rst), .enable_req_i(en8), .clk_en_o(clk_en8), .quiesced_o(quiesced8),
        .tcdm_req_i(req8), .tcdm_add_i(add8), .tcdm_wen_i(wen8), .tcdm_be_i(be8),
        .tcdm_wdata_i(wdata8), .tcdm_gnt_o(gnt8_o), .tcdm_rdata_o(rdata8_o),
        .tcdm_rvalid_o(rvalid8_o), .obi_req_o(oreq8), .obi_addr_o(oaddr8), .obi_we_o(owe8),
        .obi_be_o(obe8), .obi_wdata_o(owdata8), .obi_gnt_i(gnt8), .obi_rdata_i(rdata8),
        .obi_rvalid_i(rvalid8), .evt_i(evt8), .evt_mask_i(mask8), .evt_clr_i(clr8),
        .evt_pending_o(pend8), .int_o(int8), .err_o(err8)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of dut: outstanding count per port, mode name,
    // sticky error / pending bits, registered interrupt.
    int          m_oc [NP];
    string       m_mode = "OFF";
    logic [NP-1:0] m_err = '0;
    logic [NE-1:0] m_pend = '0;
    logic        m_int = 1'b0;

    always @(negedge clk) begin
        logic [NP-1:0] g;
        logic          a;
        bit            drained;
        logic [NE-1:0] pn;
        if (rst) begin
            for (int p = 0; p < NP; p++) m_oc[p] = 0;
            m_mode = "OFF";
            m_err  = '0;
            m_pend = '0;
            m_int  = 1'b0;
        end
        g = '0;
        for (int p = 0; p < NP; p++) begin
            a = (m_mode == "RUN") && (m_oc[p] < MO);
            g[p] = tcdm_req[p] & a & obi_gnt[p];
            chk($sformatf("m_obi_req[%0d]", p), 64'(obi_req[p]), 64'(tcdm_req[p] & a));
            chk($sformatf("m_gnt[%0d]", p), 64'(tcdm_gnt[p]), 64'(g[p]));
            chk($sformatf("m_we[%0d]", p), 64'(obi_we[p]), 64'(!tcdm_wen[p]));
            chk($sformatf("m_addr[%0d]", p), 64'(obi_addr[p*AW +: AW]), 64'(tcdm_add[p*AW +: AW]));
            chk($sformatf("m_be[%0d]", p), 64'(obi_be[p*4 +: 4]), 64'(tcdm_be[p*4 +: 4]));
            chk($sformatf("m_wdata[%0d]", p), 64'(obi_wdata[p*DW +: DW]), 64'(tcdm_wdata[p*DW +: DW]));
            chk($sformatf("m_rdata[%0d]", p), 64'(tcdm_rdata[p*DW +: DW]), 64'(obi_rdata[p*DW +: DW]));
            chk($sformatf("m_rvalid[%0d]", p), 64'(tcdm_rvalid[p]), 64'(obi_rvalid[p]));
        end
        chk("m_err", 64'(err), 64'(m_err));
        chk("m_clk_en", 64'(clk_en), 64'(m_mode != "OFF"));
        chk("m_quiesced", 64'(quiesced), 64'(m_mode == "OFF"));
        chk("m_pending", 64'(pending), 64'(m_pend));
        chk("m_int", 64'(int_o), 64'(m_int));
        if (!rst) begin
            drained = 1'b1;
            for (int p = 0; p < NP; p++) if (m_oc[p] != 0) drained = 1'b0;
            if (m_mode == "OFF") begin
                if (en) m_mode = "RUN";
            end else if (m_mode == "RUN") begin
                if (!en) m_mode = "DRAIN";
            end else begin
                if (en) m_mode = "RUN";
                else if (drained) m_mode = "OFF";
            end
            for (int p = 0; p < NP; p++) begin
                if (g[p] && !obi_rvalid[p]) m_oc[p]++;
                else if (!g[p] && obi_rvalid[p]) begin
                    if (m_oc[p] == 0) m_err[p] = 1'b1;
                    else m_oc[p]--;
                end
            end
            pn = (m_pend & ~evt_clr) | evt;
            m_pend = pn;
            m_int  = |(pn & evt_mask);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Requests and grants held high during reset must not leak through.
        tcdm_req = '1; obi_gnt = '1; req8 = '1; gnt8 = '1;
        step; step; #1;
        chk("rst_obi_req", 64'(obi_req), 64'h0);
        chk("rst_gnt", 64'(tcdm_gnt), 64'h0);
        chk("rst_clk_en", 64'(clk_en), 64'h0);
        chk("rst_quiesced", 64'(quiesced), 64'h1);
        chk("rst_gnt8", 64'(gnt8_o), 64'h0);
        tcdm_req = '0; obi_gnt = '0; req8 = '0; gnt8 = '0;
        rst = 1'b0;
        step;

        // Off -> on in one cycle
        en = 1'b1; #1;
        chk("off_clk_en", 64'(clk_en), 64'h0);
        step; #1;
        chk("on_clk_en", 64'(clk_en), 64'h1);
        chk("on_quiesced", 64'(quiesced), 64'h0);

        // Port 2 write, grants capped at two outstanding
        tcdm_req[2] = 1'b1; tcdm_wen[2] = 1'b0; tcdm_be[11:8] = 4'hF;
        tcdm_add[2*AW +: AW] = 32'h2000_0040; tcdm_wdata[2*DW +: DW] = 32'hDEAD_BEEF;
        obi_gnt[2] = 1'b1; #1;
        chk("p2_we", 64'(obi_we[2]), 64'h1);
        chk("p2_addr", 64'(obi_addr[2*AW +: AW]), 64'h2000_0040);
        chk("p2_wdata", 64'(obi_wdata[2*DW +: DW]), 64'hDEAD_BEEF);
        chk("p2_gnt0", 64'(tcdm_gnt[2]), 64'h1);
        step; #1;
        chk("p2_gnt1", 64'(tcdm_gnt[2]), 64'h1);
        step; #1;
        chk("p2_gnt_cap", 64'(tcdm_gnt[2]), 64'h0);
        chk("p2_req_cap", 64'(obi_req[2]), 64'h0);
        step;
        obi_rvalid[2] = 1'b1; obi_rdata[2*DW +: DW] = 32'h1234_5678; #1;
        chk("p2_rdata", 64'(tcdm_rdata[2*DW +: DW]), 64'h1234_5678);
        chk("p2_gnt_rv", 64'(tcdm_gnt[2]), 64'h0);
        step; obi_rvalid[2] = 1'b0; #1;
        chk("p2_gnt_again", 64'(tcdm_gnt[2]), 64'h1);
        step; #1;
        chk("p2_gnt_once", 64'(tcdm_gnt[2]), 64'h0);
        tcdm_req[2] = 1'b0; obi_gnt[2] = 1'b0; obi_rvalid[2] = 1'b1;
        step; step; obi_rvalid[2] = 1'b0;

        // Port 0: grant+rvalid together keeps the count, then an orphan rvalid
        tcdm_req[0] = 1'b1; obi_gnt[0] = 1'b1;
        step; obi_rvalid[0] = 1'b1; #1;
        chk("p0_gnt_both", 64'(tcdm_gnt[0]), 64'h1);
        step; obi_rvalid[0] = 1'b0; #1;
        chk("p0_gnt_after_both", 64'(tcdm_gnt[0]), 64'h1);
        step; #1;
        chk("p0_gnt_cap", 64'(tcdm_gnt[0]), 64'h0);
        tcdm_req[0] = 1'b0; obi_gnt[0] = 1'b0; obi_rvalid[0] = 1'b1;
        step; step; #1;
        chk("p0_err_before", 64'(err[0]), 64'h0);
        step; obi_rvalid[0] = 1'b0; #1;
        chk("p0_err_set", 64'(err[0]), 64'h1);
        step; step; #1;
        chk("p0_err_sticky", 64'(err[0]), 64'h1);

        // Drain with port 1 holding two outstanding
        tcdm_req[1] = 1'b1; obi_gnt[1] = 1'b1;
        step; step; #1;
        chk("p1_cap", 64'(tcdm_gnt[1]), 64'h0);
        en = 1'b0;
        step; #1;
        chk("drain_req", 64'(obi_req), 64'h0);
        chk("drain_clk_en", 64'(clk_en), 64'h1);
        obi_rvalid[1] = 1'b1;
        step; step; obi_rvalid[1] = 1'b0; #1;
        chk("drain_last", 64'(clk_en), 64'h1);
        step; #1;
        chk("drain_off_clk_en", 64'(clk_en), 64'h0);
        chk("drain_off_quiesced", 64'(quiesced), 64'h1);
        tcdm_req[1] = 1'b0; obi_gnt[1] = 1'b0;

        // Re-enable during drain
        en = 1'b1; step;
        tcdm_req[3] = 1'b1; obi_gnt[3] = 1'b1;
        step; step;
        en = 1'b0; step; #1;
        chk("re_drain_req3", 64'(obi_req[3]), 64'h0);
        en = 1'b1; step; #1;
        chk("re_run_clk_en", 64'(clk_en), 64'h1);
        chk("re_run_quiesced", 64'(quiesced), 64'h0);
        chk("re_run_gnt3_cap", 64'(tcdm_gnt[3]), 64'h0);
        tcdm_req[3] = 1'b0; obi_gnt[3] = 1'b0; obi_rvalid[3] = 1'b1;
        step; step; obi_rvalid[3] = 1'b0;

        // Drain with nothing outstanding lasts one cycle
        en = 1'b0; step; #1;
        chk("zdrain_clk_en", 64'(clk_en), 64'h1);
        step; #1;
        chk("zdrain_off", 64'(clk_en), 64'h0);
        chk("zdrain_quiesced", 64'(quiesced), 64'h1);

        // Events
        evt = 4'b0100; evt_mask = 4'b0100;
        step; evt = '0; #1;
        chk("evt_pend", 64'(pending), 64'h4);
        chk("evt_int", 64'(int_o), 64'h1);
        evt = 4'b0100; evt_clr = 4'b0100;
        step; evt = '0; evt_clr = '0; #1;
        chk("evt_setwins", 64'(pending), 64'h4);
        evt_clr = 4'b0100;
        step; evt_clr = '0; #1;
        chk("evt_clr_pend", 64'(pending), 64'h0);
        chk("evt_clr_int", 64'(int_o), 64'h0);
        evt = 4'b0001;
        step; evt = '0; #1;
        chk("evt_masked_pend", 64'(pending), 64'h1);
        chk("evt_masked_int", 64'(int_o), 64'h0);
        evt_mask = 4'b0001; #1;
        chk("mask_int_lag", 64'(int_o), 64'h0);
        step; #1;
        chk("mask_int_follow", 64'(int_o), 64'h1);
        evt_mask = '0; evt_clr = '1;
        step; evt_clr = '0;

        // Reset mid-transaction, then the late response flags an error
        en = 1'b1; step;
        tcdm_req[1] = 1'b1; obi_gnt[1] = 1'b1;
        step; tcdm_req[1] = 1'b0; obi_gnt[1] = 1'b0;
        rst = 1'b1; #1;
        chk("mrst_err", 64'(err), 64'h0);
        chk("mrst_clk_en", 64'(clk_en), 64'h0);
        step; rst = 1'b0; en = 1'b0;
        obi_rvalid[1] = 1'b1;
        step; obi_rvalid[1] = 1'b0; #1;
        chk("mrst_late_rvalid", 64'(err), 64'h2);

        // 8-port, MAX_OUTSTANDING=1 instance
        en8 = 1'b1; step;
        req8 = '1; gnt8 = '1; #1;
        chk("p8_req", 64'(oreq8), 64'hFF);
        chk("p8_gnt", 64'(gnt8_o), 64'hFF);
        step; #1;
        chk("p8_cap", 64'(gnt8_o), 64'h00);
        step;
        rvalid8 = '1; #1;
        chk("p8_cap_rv", 64'(gnt8_o), 64'h00);
        step; rvalid8 = '0; #1;
        chk("p8_regnt", 64'(gnt8_o), 64'hFF);
        step; #1;
        chk("p8_cap2", 64'(gnt8_o), 64'h00);
        req8 = '0; gnt8 = '0; rvalid8 = '1;
        step; rvalid8 = '0; #1;
        chk("p8_err", 64'(err8), 64'h00);
        step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cgra_mp_obi_bridge.md
Name: cgra_mp_obi_bridge

Overview:
Parametrised bridge between the CGRA's N_MP TCDM-style master ports and the system OBI masters. It replaces the fixed four-port hand wiring with a generic one.
- Tracks outstanding transactions per port and caps them at MAX_OUTSTANDING.
- Runs a quiesce FSM that drives the logic clock-gate enable and only gates the clock once every port has drained.
- Aggregates CGRA events into sticky, maskable interrupt pending bits.

Parameters:
N_MP, 4, number of master ports
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTSTANDING, 2, max granted-but-unanswered requests per port (>=1)
N_EVT, 4, number of CGRA event lines

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
enable_req_i  in  1  request the CGRA logic clock on
clk_en_o  out  1  enable to the logic clock-gating cell
quiesced_o  out  1  FSM in OFF
tcdm_req_i  in  N_MP  per-port request
tcdm_add_i  in  N_MP*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
tcdm_wen_i  in  N_MP  per-port write enable, active-low
tcdm_be_i  in  N_MP*4  per-port byte enables
tcdm_wdata_i  in  N_MP*DATA_W  per-port write data
tcdm_gnt_o  out  N_MP  per-port grant
tcdm_rdata_o  out  N_MP*DATA_W  per-port read data
tcdm_rvalid_o  out  N_MP  per-port response valid
obi_req_o  out  N_MP  OBI request
obi_addr_o  out  N_MP*ADDR_W  OBI address
obi_we_o  out  N_MP  OBI write enable, active-high
obi_be_o  out  N_MP*4  OBI byte enables
obi_wdata_o  out  N_MP*DATA_W  OBI write data
obi_gnt_i  in  N_MP  OBI grant
obi_rdata_i  in  N_MP*DATA_W  OBI read data
obi_rvalid_i  in  N_MP  OBI response valid
evt_i  in  N_EVT  CGRA event pulses
evt_mask_i  in  N_EVT  interrupt enable per event
evt_clr_i  in  N_EVT  clear pending bit
evt_pending_o  out  N_EVT  sticky pending bits
int_o  out  1  interrupt
err_o  out  N_MP  sticky protocol error per port

Behaviour:
- Reset (async, rst_i=1) values:
  - FSM=OFF, clk_en_o=0, quiesced_o=1.
  - All outstanding counters=0.
  - evt_pending_o=0, int_o=0, err_o=0.
  - obi_req_o=0 and tcdm_gnt_o=0 while reset is asserted.
- Reset mid-transaction discards all tracking state; in-flight responses arriving after reset release trigger the error rule below.
- Data path is combinational per port:
  - obi_addr_o, obi_be_o and obi_wdata_o pass through unchanged.
  - obi_we_o = ~tcdm_wen_i.
  - tcdm_rdata_o = obi_rdata_i and tcdm_rvalid_o = obi_rvalid_i.
- Issue gating, per port p: allow[p] = (state==RUN) & (cnt[p] < MAX_OUTSTANDING).
  - obi_req_o[p] = tcdm_req_i[p] & allow[p].
  - tcdm_gnt_o[p] = obi_gnt_i[p] & obi_req_o[p].
- Counter cnt[p], width $clog2(MAX_OUTSTANDING+1):
  - Accepted grant only: +1.
  - rvalid only: -1.
  - Both in the same cycle: unchanged.
  - Saturation: no grant can occur at MAX because of gating.
  - rvalid with cnt==0 and no same-cycle grant: cnt stays 0 and err_o[p] sets. err_o clears only on reset.
- FSM, state register clocked on clk_i, all transitions take effect on the next edge:
  - OFF: clk_en_o=0, quiesced_o=1. enable_req_i=1 -> RUN.
  - RUN: clk_en_o=1. enable_req_i=0 -> DRAIN.
  - DRAIN: clk_en_o=1 and new issues blocked (allow=0); responses are still counted.
    - enable_req_i=1 -> RUN; this takes priority.
    - Otherwise all cnt==0 -> OFF.
  - Minimum off->on latency is 1 cycle. DRAIN with all counters already 0 lasts exactly 1 cycle.
- Events, per bit i, registered:
  - evt_i[i]=1 sets pending[i].
  - evt_clr_i[i]=1 clears pending[i].
  - Set and clear in the same cycle: set wins.
  - Events are captured in every FSM state.
- int_o is registered: int_o <= |(pending_next & evt_mask_i). It asserts 1 cycle after the event edge and follows mask changes 1 cycle later.

Test Plan:
- Reset, then enable_req_i=1 -> clk_en_o=1 and quiesced_o=0 one cycle later; all tcdm_gnt_o=0 until then.
- Port 2: tcdm_req=1, wen=0, add=0x2000_0040, wdata=0xDEADBEEF, gnt=1 held -> obi_we_o[2]=1 with matching addr/data. With no rvalid, grants stop after 2 (cnt=2); one rvalid -> exactly one more grant.
- Grant and rvalid in the same cycle on port 0 with cnt=1 -> cnt remains 1; a later rvalid with cnt=0 -> err_o[0]=1, sticky until reset.
- RUN with cnt[1]=2, drop enable_req_i:
  - -> DRAIN, obi_req_o=0.
  - After 2 rvalids -> OFF next cycle, clk_en_o=0.
  - Reasserting enable during DRAIN -> back to RUN, clk_en_o stays 1.
- evt_i=4'b0100 with mask=4'b0100 -> pending=4'b0100 and int_o=1 the next cycle. Clear and event together -> stays set. Clear alone -> int_o=0 one cycle later. Masked event sets pending only.
- N_MP=8, MAX_OUTSTANDING=1 build: all 8 ports issue concurrently, each limited to one outstanding transaction.
